// File: rtl/fp_accum_pkg.sv
// Shared definitions for the streaming floating-point sum-reduction unit.
// Holds the fixed fp_add latency, the canonical quiet NaN and the FSM state type.
package fp_accum_pkg;

  localparam int FP_ADD_LAT = 5;
  localparam logic [31:0] NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    ADD     = 2'd2,
    OUT     = 2'd3
  } state_t;

endpackage

// File: rtl/fp_add.sv
// IEEE-754 adder with round-to-nearest-even, operands latched on start.
// done pulses FP_ADD_LAT cycles after start, plus an early pulse at +1 for NaN/Inf operands.
module fp_add
  import fp_accum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] res,
  output logic              done,
  output logic              overflow,
  output logic              underflow,
  output logic              exception
);
  localparam int MAN_W = DATA_W - EXP_W - 1;
  localparam int W     = MAN_W + 4;
  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [DATA_W-1:0]     a_r, b_r, big, res_c;
  logic [DATA_W-2:0]     small_m;
  logic [FP_ADD_LAT-1:0] pipe;
  logic [EXP_W-1:0]      eb, es, d, e_f;
  logic [EXP_W+1:0]      e_n;
  logic [W-1:0]          mb, ms, lost, sh, norm;
  logic [W:0]            sum;
  logic [MAN_W+1:0]      rnd;
  logic [MAN_W-1:0]      man;
  logic a_spec, b_spec, a_nan, b_nan, sub, big_is_a, round_up, hid, ovf, exc, norm_path;
  int lz, amt;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      pipe <= '0;
    end else begin
      pipe <= {pipe[FP_ADD_LAT-2:0], start};
      if (start) begin
        a_r <= op_a;
        b_r <= op_b;
      end
    end
  end

  // Align the smaller magnitude to the larger, keeping guard/round/sticky below the LSB.
  always_comb begin
    a_spec   = &a_r[DATA_W-2 -: EXP_W];
    b_spec   = &b_r[DATA_W-2 -: EXP_W];
    a_nan    = a_spec && (|a_r[MAN_W-1:0]);
    b_nan    = b_spec && (|b_r[MAN_W-1:0]);
    sub      = a_r[DATA_W-1] ^ b_r[DATA_W-1];
    big_is_a = a_r[DATA_W-2:0] >= b_r[DATA_W-2:0];
    big      = big_is_a ? a_r : b_r;
    small_m  = big_is_a ? b_r[DATA_W-2:0] : a_r[DATA_W-2:0];
    eb = (big[DATA_W-2 -: EXP_W] == '0) ? EXP_W'(1) : big[DATA_W-2 -: EXP_W];
    es = (small_m[DATA_W-2 -: EXP_W] == '0) ? EXP_W'(1) : small_m[DATA_W-2 -: EXP_W];
    mb   = {|big[DATA_W-2 -: EXP_W], big[MAN_W-1:0], 3'b000};
    ms   = {|small_m[DATA_W-2 -: EXP_W], small_m[MAN_W-1:0], 3'b000};
    d    = eb - es;
    lost = ~({W{1'b1}} << d);
    sh   = (ms >> d) | W'(|(ms & lost));
    sum  = sub ? ({1'b0, mb} - {1'b0, sh}) : ({1'b0, mb} + {1'b0, sh});
    e_n  = {2'b00, eb};
    lz   = W;
    amt  = 0;
    norm = '0;
    if (sum[W]) begin
      norm = sum[W:1] | W'(sum[0]);
      e_n  = e_n + (EXP_W+2)'(1);
    end else begin
      norm = sum[W-1:0];
      for (int i = 0; i < W; i++) if (norm[i]) lz = W - 1 - i;
      // Never normalise below the minimum exponent; the result then stays subnormal.
      amt  = (lz < int'(eb) - 1) ? lz : int'(eb) - 1;
      norm = norm << amt;
      e_n  = e_n - (EXP_W+2)'(amt);
    end
    round_up = norm[2] && ((|norm[1:0]) || norm[3]);
    rnd      = {1'b0, norm[W-1:3]} + (MAN_W+2)'(round_up);
    if (rnd[MAN_W+1]) begin
      e_n = e_n + (EXP_W+2)'(1);
      man = '0;
      hid = 1'b1;
    end else begin
      man = rnd[MAN_W-1:0];
      hid = rnd[MAN_W];
    end
    e_f       = hid ? e_n[EXP_W-1:0] : '0;
    ovf       = e_n >= {2'b00, {EXP_W{1'b1}}};
    exc       = a_nan | b_nan | (a_spec & b_spec & sub);
    norm_path = !a_spec && !b_spec && (sum != '0);
    if (exc)               res_c = QNAN;
    else if (a_spec)       res_c = a_r;
    else if (b_spec)       res_c = b_r;
    else if (sum == '0)    res_c = {a_r[DATA_W-1] & b_r[DATA_W-1], {(DATA_W-1){1'b0}}};
    else if (ovf)          res_c = {big[DATA_W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                   res_c = {big[DATA_W-1], e_f, man};
  end

  assign res       = res_c;
  assign done      = pipe[FP_ADD_LAT-1] | (pipe[0] & (a_spec | b_spec));
  assign overflow  = norm_path & ovf;
  assign underflow = norm_path & !ovf & !hid;
  assign exception = exc;

endmodule

// File: rtl/fp_accum.sv
// Streaming sum-reduction: folds a valid/ready vector through one serial fp_add,
// waiting the full adder latency per element so early/late done pulses never overlap.
module fp_accum
  import fp_accum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);
  localparam int LAT_W = $clog2(FP_ADD_LAT + 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, opb, res;
  logic [CNT_W-1:0]  cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              last_r, got, start, done, accept, lat_end;
  logic [2:0]        unused_flags;

  assign in_ready  = (state == IDLE) || (state == WAIT_IN);
  assign accept    = in_valid & in_ready;
  assign busy      = state != IDLE;
  assign out_valid = state == OUT;
  assign out_data  = acc;
  assign out_count = cnt;
  assign lat_end   = lat_cnt == LAT_W'(FP_ADD_LAT);
  assign start     = (state == ADD) && (lat_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? OUT : WAIT_IN;
      WAIT_IN: if (accept) state_nxt = ADD;
      ADD:     if (lat_end) state_nxt = last_r ? OUT : WAIT_IN;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first element is loaded raw; only the first done of each ADD updates the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      opb     <= '0;
      cnt     <= '0;
      lat_cnt <= '0;
      last_r  <= 1'b0;
      got     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc <= in_data;
          cnt <= CNT_W'(1);
        end
        WAIT_IN: if (accept) begin
          opb     <= in_data;
          last_r  <= in_last;
          cnt     <= (&cnt) ? cnt : cnt + CNT_W'(1);
          lat_cnt <= '0;
          got     <= 1'b0;
        end
        ADD: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (done && !got) begin
            acc <= res;
            got <= 1'b1;
          end
          if (lat_end) assert (got || done);
        end
        OUT: if (out_ready) begin
          acc <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  fp_add #(
    .DATA_W(DATA_W),
    .EXP_W (EXP_W)
  ) u_add (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (acc),
    .op_b     (opb),
    .res      (res),
    .done     (done),
    .overflow (unused_flags[0]),
    .underflow(unused_flags[1]),
    .exception(unused_flags[2])
  );

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum: sums, single element, infinities, backpressure,
// reset mid-add, and count saturation on a narrow-counter instance.
module tb_fp_accum;
  import fp_accum_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;
  logic [15:0] out_count;
  logic        in_valid_s, in_ready_s, in_last_s, out_valid_s, out_ready_s, busy_s;
  logic [31:0] in_data_s, out_data_s;
  logic [1:0]  out_count_s;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int start_cnt = 0;

  fp_accum #(.DATA_W(32), .EXP_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .busy(busy)
  );

  fp_accum #(.DATA_W(32), .EXP_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
    .in_last(in_last_s), .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
    .out_count(out_count_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.start) start_cnt <= start_cnt + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one element and hold it until accepted; t is the accepting cycle.
  task automatic apply_stimulus(input logic [31:0] d, input logic l, output int t);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check_output("accept_ready", in_ready, 1);
    t = cyc;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_out(output int t);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check_output("out_valid_seen", out_valid, 1);
    t = cyc;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_output("pop_in_ready", in_ready, 1);
    check_output("pop_out_valid", out_valid, 0);
    check_output("pop_busy", busy, 0);
  endtask

  initial begin
    int t1, t2, t3, to, s0, n;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    in_valid_s = 1'b0; in_data_s = '0; in_last_s = 1'b0; out_ready_s = 1'b0;
    repeat (2) step();
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 32'h0);
    check_output("rst_out_count", out_count, 0);
    check_output("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // 1.0 + 2.0 + 3.0 = 6.0
    apply_stimulus(32'h3F80_0000, 1'b0, t1);
    apply_stimulus(32'h4000_0000, 1'b0, t2);
    check_output("sum_first_add_immediate", t2 - t1, 1);
    apply_stimulus(32'h4040_0000, 1'b1, t3);
    check_output("sum_accept_spacing", t3 - t2, 7);
    wait_out(to);
    check_output("sum_out_latency", to - t3, 7);
    check_output("sum_out_data", out_data, 32'h40C0_0000);
    check_output("sum_out_count", out_count, 3);
    pop();
    check_output("sum_cleared_count", out_count, 0);

    // Single -0.0 element: passes through raw, no adder start
    s0 = start_cnt;
    apply_stimulus(32'h8000_0000, 1'b1, t1);
    check_output("single_out_valid", out_valid, 1);
    check_output("single_out_data", out_data, 32'h8000_0000);
    check_output("single_out_count", out_count, 1);
    check_output("single_no_start", start_cnt - s0, 0);
    pop();

    // +Inf + -Inf = NaN; the early and late done must both be absorbed
    s0 = start_cnt;
    apply_stimulus(32'h7F80_0000, 1'b0, t1);
    apply_stimulus(32'hFF80_0000, 1'b1, t2);
    wait_out(to);
    check_output("inf_out_latency", to - t2, 7);
    check_output("inf_out_data", out_data, NAN);
    check_output("inf_out_count", out_count, 2);
    check_output("inf_one_start", start_cnt - s0, 1);
    pop();

    // 1.0 + 1.0 = 2.0 with 10 cycles of output backpressure and a pending input
    apply_stimulus(32'h3F80_0000, 1'b0, t1);
    apply_stimulus(32'h3F80_0000, 1'b1, t2);
    wait_out(to);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_output("bp_out_valid", out_valid, 1);
      check_output("bp_out_data", out_data, 32'h4000_0000);
      check_output("bp_out_count", out_count, 2);
      check_output("bp_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    pop();

    // Reset in the middle of an add, then 2.0 + 2.0 = 4.0
    apply_stimulus(32'h3F80_0000, 1'b0, t1);
    apply_stimulus(32'h4000_0000, 1'b0, t2);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("midrst_in_ready", in_ready, 1);
    check_output("midrst_out_valid", out_valid, 0);
    check_output("midrst_out_data", out_data, 32'h0);
    check_output("midrst_out_count", out_count, 0);
    check_output("midrst_busy", busy, 0);
    apply_stimulus(32'h4000_0000, 1'b0, t1);
    apply_stimulus(32'h4000_0000, 1'b1, t2);
    wait_out(to);
    check_output("after_rst_latency", to - t2, 7);
    check_output("after_rst_out_data", out_data, 32'h4080_0000);
    check_output("after_rst_out_count", out_count, 2);
    pop();

    // Five zeros into a 2-bit counter saturate at 3
    for (int i = 0; i < 5; i++) begin
      in_valid_s = 1'b1;
      in_data_s  = 32'h0;
      in_last_s  = (i == 4);
      n = 0;
      while (!in_ready_s && n < 50) begin
        step();
        n++;
      end
      check_output("sat_accept_ready", in_ready_s, 1);
      step();
    end
    in_valid_s = 1'b0;
    in_last_s  = 1'b0;
    n = 0;
    while (!out_valid_s && n < 50) begin
      step();
      n++;
    end
    check_output("sat_out_valid", out_valid_s, 1);
    check_output("sat_out_count", out_count_s, 3);
    check_output("sat_out_data", out_data_s, 32'h0);
    out_ready_s = 1'b1;
    step();
    out_ready_s = 1'b0;
    check_output("sat_pop_idle", busy_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
